axis_pkt_fifo: RTL
==================

# axis_pkt_fifo

Parametrised AXI4-Stream synchronous FIFO carrying TDATA/TKEEP/TUSER/TLAST. It supports two modes: cut-through (first-word-fall-through) and packet store-and-forward. It exposes fill level, complete-packet count and an almost-full flag. It sits between stream producers and consumers in the AXI-Stream datapath as the standard elastic buffer.

## Interface
- DATA_WIDTH, 32, TDATA width; multiple of 8.
- USER_WIDTH, 1, TUSER width; ≥1.
- DEPTH, 16, entries; power of 2, ≥2.
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward.
- AFULL_THRESH, DEPTH-2, almost_full asserts when fill_level ≥ this value.
- clk, input, 1, clock; all logic on its rising edge.
- reset_n, input, 1, asynchronous, active-low reset.
- S_TDATA, input, DATA_WIDTH, write data.
- S_TKEEP, input, DATA_WIDTH/8, byte qualifiers; stored unmodified.
- S_TUSER, input, USER_WIDTH, sideband; stored unmodified.
- S_TLAST, input, 1, end of packet.
- S_TVALID, input, 1, write valid.
- S_TREADY, output, 1, space available.
- M_TDATA / M_TKEEP / M_TUSER / M_TLAST, output, as S_*, head entry.
- M_TVALID, output, 1, head entry is presentable.
- M_TREADY, input, 1, consumer ready.
- fill_level, output, $clog2(DEPTH)+1, stored entries, 0..DEPTH.
- pkt_count, output, $clog2(DEPTH)+1, complete packets (TLAST entries) stored.
- almost_full, output, 1, fill_level ≥ AFULL_THRESH.

## Operation
- Write: a write is accepted when S_TVALID && S_TREADY. The beat {data, keep, user, last} goes to mem[wr_ptr], and wr_ptr increments by 1.
- Read: a read occurs when M_TVALID && M_TREADY, and rd_ptr increments by 1.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- S_TREADY = (fill_level < DEPTH) while out of reset, and 0 while reset_n is low. It does not depend on M_TREADY, so there is no pass-through when full.
- fill_level: +1 on write only, -1 on read only, unchanged on simultaneous write and read.
- pkt_count: +1 on an accepted write with S_TLAST, -1 on a read with M_TLAST. It is unchanged when both occur in the same cycle.
- M_TDATA/KEEP/USER/LAST always reflect mem[rd_ptr] (asynchronous read). Their values are don't-care while M_TVALID = 0.
- Cut-through mode (PACKET_MODE=0): M_TVALID = (fill_level > 0).
- Store-and-forward mode (PACKET_MODE=1): M_TVALID = (fill_level > 0) && (pkt_count > 0 || flush).
- flush register (packet mode only), anti-deadlock for packets longer than DEPTH:
  - Set when fill_level == DEPTH && pkt_count == 0.
  - Cleared on the cycle a beat with M_TLAST is read.
  - While flush is set, the FIFO behaves as cut-through.
- Reset mid-operation: pointers, fill_level, pkt_count and flush return to 0 immediately and all contents are discarded. Memory contents are not reset.

## Timing
- Reset values: S_TREADY=0 during reset and 1 on the first clk after release; M_TVALID=0, fill_level=0, pkt_count=0, almost_full=0 (AFULL_THRESH>0).
- Cut-through latency: a beat accepted at edge N gives M_TVALID=1 after edge N (one cycle).
- Store-and-forward latency: M_TVALID rises the cycle after the TLAST beat is accepted. Earlier beats of that packet are held.
- Full: at fill_level==DEPTH, S_TREADY=0. A read at edge N re-asserts S_TREADY after edge N.
- Empty: at fill_level==0, M_TVALID=0. A write while empty is not visible in the same cycle.
- A simultaneous read and write when full is impossible (S_TREADY=0). When empty, only the write takes effect.
- Throughput: one beat per clock in and out simultaneously.
- All outputs derive from registers only; there is no combinational path from S_* to M_* or from M_TREADY to S_TREADY.

## Structure
- Package axis_pkg holds:
  - Parametrised beat struct typedef axis_beat_t {data, keep, user, last}, or an equivalent packing function.
  - Mode constants AXIS_CUT_THROUGH=0 and AXIS_STORE_FWD=1.
- Sub-module axis_fifo_ram: simple dual-port storage, DEPTH × beat width, synchronous write and asynchronous read. It holds no control logic.
- Top level holds the pointers, counters, flush register and flag logic.

## Test plan
- Reset and basic flow (DEPTH=16, cut-through): write 0x00000001..0x00000004 with TLAST on the 4th, M_TREADY=1 → same data out in order, M_TVALID 1 cycle after the first write, M_TLAST only with 0x4, fill_level returns to 0.
- Full and empty with wrap (M_TREADY=0): write 16 beats → S_TREADY=0 at fill_level=16 and almost_full=1 from fill_level 14. Then read all 16 and write 16 more → pointers wrap, data intact, M_TVALID=0 at empty.
- Simultaneous write and read at fill_level=5 for 20 cycles → fill_level stays 5, output sequence is contiguous, TKEEP=0x3 and TUSER=1 pass through unchanged.
- Store-and-forward (PACKET_MODE=1): send a 3-beat packet → M_TVALID stays 0 until the cycle after the TLAST beat, then pkt_count=1. Read the packet → pkt_count returns to 0.
- Oversize packet (PACKET_MODE=1, DEPTH=16): send a 40-beat packet with M_TREADY=1 → flush sets at fill_level=16 and all 40 beats drain in order. flush clears on TLAST, and the next 2-beat packet is held until its TLAST.
- Reset mid-packet: assert reset_n=0 after 6 of 10 beats → fill_level=0, pkt_count=0, M_TVALID=0 immediately. After release, a new packet flows normally.

Source files
------------

// File: rtl/axis_pkg.sv
// axis_pkg: shared mode constants and beat sizing helper for AXI-Stream FIFOs
package axis_pkg;
    localparam int AXIS_CUT_THROUGH = 0;
    localparam int AXIS_STORE_FWD   = 1;
    function automatic int axis_beat_bits(input int data_width, input int user_width);
        return data_width + data_width / 8 + user_width + 1;
    endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port storage, synchronous write, asynchronous read
module axis_fifo_ram #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI4-Stream FIFO with cut-through and store-and-forward modes
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int USER_WIDTH   = 1,
    parameter int DEPTH        = 16,
    parameter int PACKET_MODE  = AXIS_CUT_THROUGH,
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      S_TDATA,
    input  logic [DATA_WIDTH/8-1:0]    S_TKEEP,
    input  logic [USER_WIDTH-1:0]      S_TUSER,
    input  logic                       S_TLAST,
    input  logic                       S_TVALID,
    output logic                       S_TREADY,
    output logic [DATA_WIDTH-1:0]      M_TDATA,
    output logic [DATA_WIDTH/8-1:0]    M_TKEEP,
    output logic [USER_WIDTH-1:0]      M_TUSER,
    output logic                       M_TLAST,
    output logic                       M_TVALID,
    input  logic                       M_TREADY,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AFULL_THRESH);
    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] keep;
        logic [USER_WIDTH-1:0]   user;
        logic                    last;
    } axis_beat_t;
    axis_beat_t wr_beat, rd_beat;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic run, flush, wr, rd;
    assign wr_beat = '{data: S_TDATA, keep: S_TKEEP, user: S_TUSER, last: S_TLAST};
    axis_fifo_ram #(.WIDTH(axis_beat_bits(DATA_WIDTH, USER_WIDTH)), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr),
        .wdata (wr_beat),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );
    // run keeps S_TREADY low until the first edge after reset release
    always_comb begin
        S_TREADY    = run && fill_level != FULL;
        M_TVALID    = fill_level != '0 && (PACKET_MODE == AXIS_CUT_THROUGH || pkt_count != '0 || flush);
        wr          = S_TVALID && S_TREADY;
        rd          = M_TVALID && M_TREADY;
        almost_full = fill_level >= AF;
        M_TDATA     = rd_beat.data;
        M_TKEEP     = rd_beat.keep;
        M_TUSER     = rd_beat.user;
        M_TLAST     = rd_beat.last;
    end
    // flush breaks the deadlock of a packet that cannot fit: full with no TLAST stored
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            pkt_count  <= '0;
            flush      <= 1'b0;
        end else begin
            run        <= 1'b1;
            wr_ptr     <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= rd ? rd_ptr + AW'(1) : rd_ptr;
            fill_level <= fill_level + CW'(wr) - CW'(rd);
            pkt_count  <= pkt_count + CW'(wr && S_TLAST) - CW'(rd && rd_beat.last);
            if (rd && rd_beat.last)
                flush <= 1'b0;
            else if (PACKET_MODE == AXIS_STORE_FWD && fill_level == FULL && pkt_count == '0)
                flush <= 1'b1;
        end
    end
endmodule
